// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between instruction fetch (IF)
// and data memory (DM) requesters. One access at a time, registered memory bus,
// one-cycle ready pulse per completion, error completion on bus timeout.
module mem_port_arbiter #(
    parameter int unsigned AW         = 32,
    parameter int unsigned DW         = 32,
    parameter int unsigned TIMEOUT    = 15,
    parameter int unsigned STARVE_LIM = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_ready,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic [DW-1:0] dm_rdata,
    output logic          dm_ready,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,
    output logic          err,
    output logic          stall_f,
    output logic          stall_m
);

    localparam int unsigned WCW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam int unsigned SCW = (STARVE_LIM > 0) ? $clog2(STARVE_LIM + 1) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_DM = 1'b1;

    logic [1:0]     state, state_nxt;
    logic           owner, owner_nxt;
    logic [WCW-1:0] wait_cnt, wait_cnt_nxt;
    logic [SCW-1:0] starve_cnt, starve_cnt_nxt;
    logic           mem_req_nxt, mem_we_nxt;
    logic [AW-1:0]  mem_addr_nxt;
    logic [DW-1:0]  mem_wdata_nxt;
    logic [DW-1:0]  if_rdata_nxt, dm_rdata_nxt;
    logic           if_ready_nxt, dm_ready_nxt, err_nxt;
    logic           pick_if;
    logic           done;
    logic [DW-1:0]  resp_data;

    // Next-state and next-output logic for the IDLE -> BUSY -> RESP cycle.
    always_comb begin
        state_nxt      = state;
        owner_nxt      = owner;
        wait_cnt_nxt   = wait_cnt;
        starve_cnt_nxt = starve_cnt;
        mem_req_nxt    = mem_req;
        mem_we_nxt     = mem_we;
        mem_addr_nxt   = mem_addr;
        mem_wdata_nxt  = mem_wdata;
        if_rdata_nxt   = if_rdata;
        dm_rdata_nxt   = dm_rdata;
        if_ready_nxt   = 1'b0;
        dm_ready_nxt   = 1'b0;
        err_nxt        = 1'b0;
        pick_if        = 1'b0;
        done           = 1'b0;
        resp_data      = '0;

        // Starvation history only matters while a fetch is actually waiting.
        if (!if_req) begin
            starve_cnt_nxt = '0;
        end

        case (state)
            IDLE: begin
                if (if_req || dm_req) begin
                    pick_if      = if_req && (!dm_req || (starve_cnt == SCW'(STARVE_LIM)));
                    state_nxt    = BUSY;
                    mem_req_nxt  = 1'b1;
                    wait_cnt_nxt = '0;
                    if (pick_if) begin
                        owner_nxt      = OWN_IF;
                        mem_addr_nxt   = if_addr;
                        mem_we_nxt     = 1'b0;
                        mem_wdata_nxt  = '0;
                        starve_cnt_nxt = '0;
                    end else begin
                        owner_nxt     = OWN_DM;
                        mem_addr_nxt  = dm_addr;
                        mem_we_nxt    = dm_we;
                        mem_wdata_nxt = dm_wdata;
                        if (if_req && (starve_cnt != SCW'(STARVE_LIM))) begin
                            starve_cnt_nxt = starve_cnt + SCW'(1);
                        end
                    end
                end
            end
            BUSY: begin
                wait_cnt_nxt = wait_cnt + WCW'(1);
                // Ack takes priority over a coincident timeout.
                if (mem_ack) begin
                    done      = 1'b1;
                    resp_data = mem_we ? '0 : mem_rdata;
                end else if (wait_cnt == WCW'(TIMEOUT - 1)) begin
                    done      = 1'b1;
                    resp_data = '0;
                    err_nxt   = 1'b1;
                end
                if (done) begin
                    state_nxt   = RESP;
                    mem_req_nxt = 1'b0;
                    mem_we_nxt  = 1'b0;
                    if (owner == OWN_IF) begin
                        if_rdata_nxt = resp_data;
                        if_ready_nxt = 1'b1;
                    end else begin
                        dm_rdata_nxt = resp_data;
                        dm_ready_nxt = 1'b1;
                    end
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt   = IDLE;
                mem_req_nxt = 1'b0;
                mem_we_nxt  = 1'b0;
            end
        endcase
    end

    // State and registered outputs, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            owner      <= OWN_IF;
            wait_cnt   <= '0;
            starve_cnt <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            if_rdata   <= '0;
            dm_rdata   <= '0;
            if_ready   <= 1'b0;
            dm_ready   <= 1'b0;
            err        <= 1'b0;
        end else begin
            state      <= state_nxt;
            owner      <= owner_nxt;
            wait_cnt   <= wait_cnt_nxt;
            starve_cnt <= starve_cnt_nxt;
            mem_req    <= mem_req_nxt;
            mem_we     <= mem_we_nxt;
            mem_addr   <= mem_addr_nxt;
            mem_wdata  <= mem_wdata_nxt;
            if_rdata   <= if_rdata_nxt;
            dm_rdata   <= dm_rdata_nxt;
            if_ready   <= if_ready_nxt;
            dm_ready   <= dm_ready_nxt;
            err        <= err_nxt;
        end
    end

    // Pipeline stalls follow the request immediately, released by the ready pulse.
    assign stall_f = if_req & ~if_ready;
    assign stall_m = dm_req & ~dm_ready;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: reset, fetch, store with waits,
// starvation ordering, timeout and reset during an access.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_ready;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        err;
    logic        stall_f;
    logic        stall_m;

    int errors = 0;
    int checks = 0;

    mem_port_arbiter #(
        .AW(32), .DW(32), .TIMEOUT(15), .STARVE_LIM(2)
    ) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_ready(dm_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .err(err), .stall_f(stall_f), .stall_m(stall_m)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    logic [5:0]  order_if;
    logic        exp_if;
    logic [31:0] exp_addr;

    initial begin
        reset     = 1'b0;
        if_req    = 1'b1;
        dm_req    = 1'b1;
        dm_we     = 1'b0;
        if_addr   = 32'h0000_0200;
        dm_addr   = 32'h0000_0100;
        dm_wdata  = 32'h5555_AAAA;
        mem_rdata = 32'h0;
        mem_ack   = 1'b0;

        // Reset with both requests asserted
        step();
        step();
        chk1 ("rst_mem_req",   mem_req,   1'b0);
        chk1 ("rst_mem_we",    mem_we,    1'b0);
        chk1 ("rst_if_ready",  if_ready,  1'b0);
        chk1 ("rst_dm_ready",  dm_ready,  1'b0);
        chk1 ("rst_err",       err,       1'b0);
        chk32("rst_mem_addr",  mem_addr,  32'h0);
        chk32("rst_mem_wdata", mem_wdata, 32'h0);
        chk32("rst_if_rdata",  if_rdata,  32'h0);
        chk32("rst_dm_rdata",  dm_rdata,  32'h0);
        chk1 ("rst_stall_f",   stall_f,   1'b1);
        chk1 ("rst_stall_m",   stall_m,   1'b1);

        // Release reset: DM wins the first grant
        reset = 1'b1;
        step();
        chk1 ("t1_mem_req",  mem_req,  1'b1);
        chk32("t1_mem_addr", mem_addr, 32'h0000_0100);
        chk1 ("t1_mem_we",   mem_we,   1'b0);
        mem_ack   = 1'b1;
        mem_rdata = 32'h1111_1111;
        step();
        chk1 ("t1_dm_ready", dm_ready, 1'b1);
        chk1 ("t1_if_ready", if_ready, 1'b0);
        chk32("t1_dm_rdata", dm_rdata, 32'h1111_1111);
        chk1 ("t1_mem_req0", mem_req,  1'b0);
        mem_ack = 1'b0;
        if_req  = 1'b0;
        dm_req  = 1'b0;
        step();
        chk1 ("t1_dm_ready0", dm_ready, 1'b0);

        // Fetch only, zero-wait memory
        if_req  = 1'b1;
        if_addr = 32'h0000_0004;
        #1;
        chk1 ("t2_stall_n", stall_f, 1'b1);
        step();
        chk1 ("t2_mem_req",  mem_req,  1'b1);
        chk32("t2_mem_addr", mem_addr, 32'h0000_0004);
        chk1 ("t2_mem_we",   mem_we,   1'b0);
        chk1 ("t2_stall_n1", stall_f,  1'b1);
        chk1 ("t2_ready_n1", if_ready, 1'b0);
        mem_ack   = 1'b1;
        mem_rdata = 32'h2008_0005;
        step();
        chk1 ("t2_if_ready", if_ready, 1'b1);
        chk32("t2_if_rdata", if_rdata, 32'h2008_0005);
        chk1 ("t2_stall_n2", stall_f,  1'b0);
        chk1 ("t2_dm_ready", dm_ready, 1'b0);
        chk1 ("t2_err",      err,      1'b0);
        mem_ack = 1'b0;
        if_req  = 1'b0;
        step();
        chk1 ("t2_if_ready0", if_ready, 1'b0);

        // Store with three wait cycles; address change while held is ignored
        dm_req   = 1'b1;
        dm_we    = 1'b1;
        dm_addr  = 32'h0000_0040;
        dm_wdata = 32'hCAFE_F00D;
        step();
        for (int k = 1; k <= 4; k++) begin
            chk1 ("t3_mem_req",   mem_req,   1'b1);
            chk1 ("t3_mem_we",    mem_we,    1'b1);
            chk32("t3_mem_addr",  mem_addr,  32'h0000_0040);
            chk32("t3_mem_wdata", mem_wdata, 32'hCAFE_F00D);
            chk1 ("t3_stall_m",   stall_m,   1'b1);
            if (k == 1) begin
                dm_addr  = 32'h0000_0080;
                dm_wdata = 32'h0BAD_0BAD;
            end
            if (k == 4) begin
                mem_ack   = 1'b1;
                mem_rdata = 32'hDEAD_BEEF;
            end
            step();
        end
        chk1 ("t3_dm_ready", dm_ready, 1'b1);
        chk32("t3_dm_rdata", dm_rdata, 32'h0);
        chk1 ("t3_err",      err,      1'b0);
        chk1 ("t3_mem_req0", mem_req,  1'b0);
        mem_ack = 1'b0;
        dm_req  = 1'b0;
        dm_we   = 1'b0;
        step();

        // Both requests held: DM, DM, IF, DM, DM, IF
        order_if = 6'b100100;
        if_req   = 1'b1;
        dm_req   = 1'b1;
        if_addr  = 32'h0000_0400;
        dm_addr  = 32'h0000_0300;
        for (int i = 0; i < 6; i++) begin
            exp_if   = order_if[i];
            exp_addr = exp_if ? 32'h0000_0400 : 32'h0000_0300;
            step();
            chk32("t4_grant_addr", mem_addr, exp_addr);
            mem_ack   = 1'b1;
            mem_rdata = 32'h0000_A000 + 32'(i);
            step();
            chk1 ("t4_if_ready", if_ready, exp_if);
            chk1 ("t4_dm_ready", dm_ready, ~exp_if);
            chk32("t4_rdata", exp_if ? if_rdata : dm_rdata, 32'h0000_A000 + 32'(i));
            mem_ack = 1'b0;
            if (i == 5) begin
                if_req = 1'b0;
                dm_req = 1'b0;
            end
            step();
        end

        // Timeout: no ack for 15 BUSY cycles
        dm_req  = 1'b1;
        dm_addr = 32'h0000_0500;
        step();
        for (int k = 1; k <= 15; k++) begin
            chk1 ("t5_mem_req_busy", mem_req,  1'b1);
            chk1 ("t5_err_busy",     err,      1'b0);
            chk1 ("t5_ready_busy",   dm_ready, 1'b0);
            step();
        end
        chk1 ("t5_mem_req0", mem_req,  1'b0);
        chk1 ("t5_dm_ready", dm_ready, 1'b1);
        chk1 ("t5_err",      err,      1'b1);
        chk32("t5_dm_rdata", dm_rdata, 32'h0);
        dm_req = 1'b0;
        step();
        chk1 ("t5_err0",      err,      1'b0);
        chk1 ("t5_dm_ready0", dm_ready, 1'b0);
        mem_ack   = 1'b1;
        mem_rdata = 32'h1234_5678;
        step();
        chk1 ("t5_stray_req",   mem_req,  1'b0);
        chk1 ("t5_stray_dm",    dm_ready, 1'b0);
        chk1 ("t5_stray_if",    if_ready, 1'b0);
        chk32("t5_stray_rdata", dm_rdata, 32'h0);
        mem_ack = 1'b0;
        step();

        // Reset during BUSY abandons the access
        if_req  = 1'b1;
        if_addr = 32'h0000_0600;
        step();
        chk1 ("t6_mem_req", mem_req, 1'b1);
        chk32("t6_mem_addr", mem_addr, 32'h0000_0600);
        reset = 1'b0;
        step();
        chk1 ("t6_rst_req",   mem_req,  1'b0);
        chk1 ("t6_rst_ready", if_ready, 1'b0);
        chk32("t6_rst_rdata", if_rdata, 32'h0);
        reset     = 1'b1;
        if_req    = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 32'h0000_0099;
        step();
        chk1 ("t6_ack_ready", if_ready, 1'b0);
        chk1 ("t6_ack_req",   mem_req,  1'b0);
        chk32("t6_ack_rdata", if_rdata, 32'h0);
        chk1 ("t6_ack_err",   err,      1'b0);
        mem_ack = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
